// File: rtl/mm2s_cmd_engine_if.sv
// Command/status, AXI4 read and AXI4-Stream signals of the MM2S command engine.
// The master modport is the engine's view; slave is the surrounding system's view.
interface mm2s_cmd_engine_if;
    logic        s_axis_mm2s_cmd_tvalid;
    logic        s_axis_mm2s_cmd_tready;
    logic [71:0] s_axis_mm2s_cmd_tdata;
    logic        m_axis_mm2s_sts_tvalid;
    logic        m_axis_mm2s_sts_tready;
    logic [7:0]  m_axis_mm2s_sts_tdata;
    logic        m_axis_mm2s_sts_tkeep;
    logic        m_axis_mm2s_sts_tlast;
    logic [3:0]  m_axi_mm2s_arid;
    logic [31:0] m_axi_mm2s_araddr;
    logic [7:0]  m_axi_mm2s_arlen;
    logic [2:0]  m_axi_mm2s_arsize;
    logic [1:0]  m_axi_mm2s_arburst;
    logic [2:0]  m_axi_mm2s_arprot;
    logic [3:0]  m_axi_mm2s_arcache;
    logic [3:0]  m_axi_mm2s_aruser;
    logic        m_axi_mm2s_arvalid;
    logic        m_axi_mm2s_arready;
    logic [63:0] m_axi_mm2s_rdata;
    logic [1:0]  m_axi_mm2s_rresp;
    logic        m_axi_mm2s_rlast;
    logic        m_axi_mm2s_rvalid;
    logic        m_axi_mm2s_rready;
    logic [63:0] m_axis_mm2s_tdata;
    logic [7:0]  m_axis_mm2s_tkeep;
    logic        m_axis_mm2s_tlast;
    logic        m_axis_mm2s_tvalid;
    logic        m_axis_mm2s_tready;

    modport master (
        input  s_axis_mm2s_cmd_tvalid, s_axis_mm2s_cmd_tdata, m_axis_mm2s_sts_tready,
               m_axi_mm2s_arready, m_axi_mm2s_rdata, m_axi_mm2s_rresp, m_axi_mm2s_rlast,
               m_axi_mm2s_rvalid, m_axis_mm2s_tready,
        output s_axis_mm2s_cmd_tready, m_axis_mm2s_sts_tvalid, m_axis_mm2s_sts_tdata,
               m_axis_mm2s_sts_tkeep, m_axis_mm2s_sts_tlast, m_axi_mm2s_arid, m_axi_mm2s_araddr,
               m_axi_mm2s_arlen, m_axi_mm2s_arsize, m_axi_mm2s_arburst, m_axi_mm2s_arprot,
               m_axi_mm2s_arcache, m_axi_mm2s_aruser, m_axi_mm2s_arvalid, m_axi_mm2s_rready,
               m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast, m_axis_mm2s_tvalid
    );

    modport slave (
        output s_axis_mm2s_cmd_tvalid, s_axis_mm2s_cmd_tdata, m_axis_mm2s_sts_tready,
               m_axi_mm2s_arready, m_axi_mm2s_rdata, m_axi_mm2s_rresp, m_axi_mm2s_rlast,
               m_axi_mm2s_rvalid, m_axis_mm2s_tready,
        input  s_axis_mm2s_cmd_tready, m_axis_mm2s_sts_tvalid, m_axis_mm2s_sts_tdata,
               m_axis_mm2s_sts_tkeep, m_axis_mm2s_sts_tlast, m_axi_mm2s_arid, m_axi_mm2s_araddr,
               m_axi_mm2s_arlen, m_axi_mm2s_arsize, m_axi_mm2s_arburst, m_axi_mm2s_arprot,
               m_axi_mm2s_arcache, m_axi_mm2s_aruser, m_axi_mm2s_arvalid, m_axi_mm2s_rready,
               m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast, m_axis_mm2s_tvalid
    );
endinterface

// File: rtl/mm2s_cmd_engine.sv
// Lightweight MM2S datamover: one 72-bit command in, AXI4 read bursts that never cross
// 4 KB, read data passed straight through to AXI4-Stream, one status byte out.
module mm2s_cmd_engine #(
    parameter int unsigned MAX_BURST_BEATS = 16,
    parameter logic [3:0]  AXI_ID          = 4'd0
) (
    input  logic aclk,
    input  logic areset,
    mm2s_cmd_engine_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STS   = 3'd4
    } state_t;

    localparam logic [9:0] MAX_LEN_C = 10'(MAX_BURST_BEATS);

    state_t      state_r, state_nxt_s;
    logic        cmd_ready_r;
    logic [3:0]  tag_r;
    logic [31:0] addr_r;
    logic        eof_r;
    // One bit wider than 20 so that a BTT just below 2^23 still yields 2^20 beats.
    logic [20:0] beats_left_r;
    logic [2:0]  last_bytes_r;
    logic        slverr_r, decerr_r, interr_r;
    logic        cmd_hs_s, r_beat_s, final_beat_s, cmd_bad_s;
    logic [9:0]  room_s, len_a_s, burst_len_s;
    logic        unused_s;

    function automatic logic [7:0] last_keep(input logic [2:0] n);
        case (n)
            3'd1:    last_keep = 8'h01;
            3'd2:    last_keep = 8'h03;
            3'd3:    last_keep = 8'h07;
            3'd4:    last_keep = 8'h0F;
            3'd5:    last_keep = 8'h1F;
            3'd6:    last_keep = 8'h3F;
            3'd7:    last_keep = 8'h7F;
            default: last_keep = 8'hFF;
        endcase
    endfunction

    assign unused_s = ^{bus.s_axis_mm2s_cmd_tdata[71:68], bus.s_axis_mm2s_cmd_tdata[31],
                        bus.s_axis_mm2s_cmd_tdata[29:23]};

    assign cmd_hs_s     = bus.s_axis_mm2s_cmd_tvalid && cmd_ready_r;
    assign r_beat_s     = (state_r == ST_DATA) && bus.m_axi_mm2s_rvalid && bus.m_axis_mm2s_tready;
    assign final_beat_s = (beats_left_r == 21'd1);
    assign cmd_bad_s    = (beats_left_r == 21'd0) || (addr_r[2:0] != 3'd0);

    // Beats left before the next 4 KB page (1..512), then clamp to remaining and max burst.
    assign room_s      = 10'((13'd4096 - {1'b0, addr_r[11:0]}) >> 3);
    assign len_a_s     = (beats_left_r < {11'd0, room_s}) ? beats_left_r[9:0] : room_s;
    assign burst_len_s = (len_a_s > MAX_LEN_C) ? MAX_LEN_C : len_a_s;

    assign bus.s_axis_mm2s_cmd_tready = cmd_ready_r;
    assign bus.m_axis_mm2s_sts_tkeep  = 1'b1;
    assign bus.m_axis_mm2s_sts_tlast  = 1'b1;
    assign bus.m_axi_mm2s_arid        = AXI_ID;
    assign bus.m_axi_mm2s_arsize      = 3'b011;
    assign bus.m_axi_mm2s_arburst     = 2'b01;
    assign bus.m_axi_mm2s_arprot      = 3'b000;
    assign bus.m_axi_mm2s_arcache     = 4'b0011;
    assign bus.m_axi_mm2s_aruser      = 4'b0000;

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and all state-dependent outputs.
    always_comb begin
        state_nxt_s                 = state_r;
        bus.m_axi_mm2s_arvalid      = 1'b0;
        bus.m_axi_mm2s_araddr       = 32'd0;
        bus.m_axi_mm2s_arlen        = 8'd0;
        bus.m_axi_mm2s_rready       = 1'b0;
        bus.m_axis_mm2s_tdata       = 64'd0;
        bus.m_axis_mm2s_tkeep       = 8'd0;
        bus.m_axis_mm2s_tlast       = 1'b0;
        bus.m_axis_mm2s_tvalid      = 1'b0;
        bus.m_axis_mm2s_sts_tvalid  = 1'b0;
        bus.m_axis_mm2s_sts_tdata   = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) state_nxt_s = ST_CHECK;
                else          state_nxt_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (cmd_bad_s) state_nxt_s = ST_STS;
                else           state_nxt_s = ST_ADDR;
            end
            ST_ADDR: begin
                bus.m_axi_mm2s_arvalid = 1'b1;
                bus.m_axi_mm2s_araddr  = addr_r;
                bus.m_axi_mm2s_arlen   = 8'(burst_len_s - 10'd1);
                if (bus.m_axi_mm2s_arready) state_nxt_s = ST_DATA;
                else                        state_nxt_s = ST_ADDR;
            end
            ST_DATA: begin
                bus.m_axis_mm2s_tdata  = bus.m_axi_mm2s_rdata;
                bus.m_axis_mm2s_tvalid = bus.m_axi_mm2s_rvalid;
                bus.m_axi_mm2s_rready  = bus.m_axis_mm2s_tready;
                bus.m_axis_mm2s_tkeep  = final_beat_s ? last_keep(last_bytes_r) : 8'hFF;
                bus.m_axis_mm2s_tlast  = eof_r && final_beat_s;
                if (r_beat_s && bus.m_axi_mm2s_rlast) state_nxt_s = final_beat_s ? ST_STS : ST_ADDR;
                else                                  state_nxt_s = ST_DATA;
            end
            ST_STS: begin
                bus.m_axis_mm2s_sts_tvalid = 1'b1;
                bus.m_axis_mm2s_sts_tdata  = {~(slverr_r | decerr_r | interr_r),
                                              slverr_r, decerr_r, interr_r, tag_r};
                if (bus.m_axis_mm2s_sts_tready) state_nxt_s = ST_IDLE;
                else                            state_nxt_s = ST_STS;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command latch, address/beat bookkeeping and sticky error flags.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cmd_ready_r  <= 1'b0;
            tag_r        <= 4'd0;
            addr_r       <= 32'd0;
            eof_r        <= 1'b0;
            beats_left_r <= 21'd0;
            last_bytes_r <= 3'd0;
            slverr_r     <= 1'b0;
            decerr_r     <= 1'b0;
            interr_r     <= 1'b0;
        end else begin
            // Ready rises one cycle after entering IDLE, leaving a gap after each status.
            cmd_ready_r <= (state_r == ST_IDLE) && !cmd_hs_s;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_hs_s) begin
                        tag_r        <= bus.s_axis_mm2s_cmd_tdata[67:64];
                        addr_r       <= bus.s_axis_mm2s_cmd_tdata[63:32];
                        eof_r        <= bus.s_axis_mm2s_cmd_tdata[30];
                        beats_left_r <= {1'b0, bus.s_axis_mm2s_cmd_tdata[22:3]}
                                        + {20'd0, |bus.s_axis_mm2s_cmd_tdata[2:0]};
                        last_bytes_r <= bus.s_axis_mm2s_cmd_tdata[2:0];
                        slverr_r     <= 1'b0;
                        decerr_r     <= 1'b0;
                        interr_r     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (cmd_bad_s) interr_r <= 1'b1;
                end
                ST_ADDR: begin
                    if (bus.m_axi_mm2s_arready) addr_r <= addr_r + {19'd0, burst_len_s, 3'b000};
                end
                ST_DATA: begin
                    if (r_beat_s) begin
                        if (beats_left_r != 21'd0) beats_left_r <= beats_left_r - 21'd1;
                        if (bus.m_axi_mm2s_rresp == 2'b10) slverr_r <= 1'b1;
                        if (bus.m_axi_mm2s_rresp == 2'b11) decerr_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
